// File: rtl/subreg_tim_seq.sv
`default_nettype none
// ============================================================================
// Module   : subreg_tim_seq
// Brief    : Burst clock-enable sequencer: N evenly spread enable pulses per
//            P clocks, optional burst length, abort, handshake configuration.
// Revision : 1.0 - initial release
// ============================================================================
module subreg_tim_seq #(
   parameter int C_PERIOD_W = 16,
   parameter int C_TICKS_W  = 16
) (
   input  logic                  CK_i,
   input  logic                  ARST_i,
   input  logic                  CFG_REQ_i,
   input  logic [C_PERIOD_W-1:0] CFG_PERIOD_i,
   input  logic [C_PERIOD_W-1:0] CFG_PULSE_N_i,
   input  logic [C_TICKS_W-1:0]  CFG_TICKS_i,
   input  logic                  ABORT_i,
   output logic                  CFG_ACK_o,
   output logic                  CFG_ERR_o,
   output logic                  BUSY_o,
   output logic                  EN_CK_o,
   output logic                  DONE_o,
   output logic [C_TICKS_W-1:0]  TICK_CTR_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]                 state_q,    state_d;
   logic [C_PERIOD_W-1:0]      period_q,   period_d;
   logic [C_PERIOD_W-1:0]      pulse_n_q,  pulse_n_d;
   logic [C_TICKS_W-1:0]       ticks_q,    ticks_d;
   logic [C_TICKS_W-1:0]       tick_ctr_q, tick_ctr_d;
   logic signed [C_PERIOD_W:0] acc_q,      acc_d;
   logic                       err_q,      err_d;

   logic                       cfg_bad;
   logic                       pulse;
   logic                       last_tick;
   logic [C_TICKS_W-1:0]       tick_inc;
   logic signed [C_PERIOD_W:0] n_ext;
   logic signed [C_PERIOD_W:0] p_add;
   logic signed [C_PERIOD_W:0] acc_step;

   assign cfg_bad   = (CFG_PERIOD_i == '0) || (CFG_PULSE_N_i == '0) ||
                      (CFG_PULSE_N_i > CFG_PERIOD_i);
   // The accumulator sign bit is the enable itself, so there is no output register.
   assign pulse     = (state_q == S_RUN) && acc_q[C_PERIOD_W];
   assign tick_inc  = tick_ctr_q + {{(C_TICKS_W-1){1'b0}}, 1'b1};
   assign last_tick = pulse && (ticks_q != '0) && (tick_inc == ticks_q);
   assign n_ext     = $signed({1'b0, pulse_n_q});
   assign p_add     = acc_q[C_PERIOD_W] ? $signed({1'b0, period_q}) : '0;
   assign acc_step  = acc_q - n_ext + p_add;

   always_comb begin
      state_d    = state_q;
      period_d   = period_q;
      pulse_n_d  = pulse_n_q;
      ticks_d    = ticks_q;
      tick_ctr_d = tick_ctr_q;
      acc_d      = acc_q;
      err_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A request still held during its own error pulse is not re-reported.
            if (CFG_REQ_i && !err_q) begin
               if (cfg_bad) begin
                  err_d = 1'b1;
               end else begin
                  period_d   = CFG_PERIOD_i;
                  pulse_n_d  = CFG_PULSE_N_i;
                  ticks_d    = CFG_TICKS_i;
                  tick_ctr_d = '0;
                  acc_d      = '0;
                  state_d    = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            state_d = ABORT_i ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            acc_d = acc_step;
            if (pulse) begin
               tick_ctr_d = tick_inc;
            end
            if (ABORT_i) begin
               state_d = S_IDLE;
            end else if (last_tick) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CK_i or posedge ARST_i) begin
      if (ARST_i) begin
         state_q    <= S_IDLE;
         period_q   <= '0;
         pulse_n_q  <= '0;
         ticks_q    <= '0;
         tick_ctr_q <= '0;
         acc_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         period_q   <= period_d;
         pulse_n_q  <= pulse_n_d;
         ticks_q    <= ticks_d;
         tick_ctr_q <= tick_ctr_d;
         acc_q      <= acc_d;
         err_q      <= err_d;
      end
   end

   assign CFG_ACK_o  = (state_q == S_LOAD);
   assign CFG_ERR_o  = err_q;
   assign BUSY_o     = (state_q != S_IDLE);
   assign EN_CK_o    = pulse;
   assign DONE_o     = (state_q == S_DONE);
   assign TICK_CTR_o = tick_ctr_q;

endmodule
`default_nettype wire

// File: tb/tb_subreg_tim_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_subreg_tim_seq
// Brief    : Self-checking bench for subreg_tim_seq (vector table + per-cycle
//            expectation queue).
// Revision : 1.0 - initial release
// ============================================================================
module tb_subreg_tim_seq;

   logic        CK_i;
   logic        ARST_i;
   logic        CFG_REQ_i;
   logic [15:0] CFG_PERIOD_i;
   logic [15:0] CFG_PULSE_N_i;
   logic [15:0] CFG_TICKS_i;
   logic        ABORT_i;
   logic        CFG_ACK_o;
   logic        CFG_ERR_o;
   logic        BUSY_o;
   logic        EN_CK_o;
   logic        DONE_o;
   logic [15:0] TICK_CTR_o;

   subreg_tim_seq #(
      .C_PERIOD_W (16),
      .C_TICKS_W  (16)
   ) u_dut (
      .CK_i          (CK_i),
      .ARST_i        (ARST_i),
      .CFG_REQ_i     (CFG_REQ_i),
      .CFG_PERIOD_i  (CFG_PERIOD_i),
      .CFG_PULSE_N_i (CFG_PULSE_N_i),
      .CFG_TICKS_i   (CFG_TICKS_i),
      .ABORT_i       (ABORT_i),
      .CFG_ACK_o     (CFG_ACK_o),
      .CFG_ERR_o     (CFG_ERR_o),
      .BUSY_o        (BUSY_o),
      .EN_CK_o       (EN_CK_o),
      .DONE_o        (DONE_o),
      .TICK_CTR_o    (TICK_CTR_o)
   );

   initial CK_i = 1'b0;
   always #5 CK_i = ~CK_i;

   typedef struct {
      int p;
      int n;
      int t;
      int abort_at;   // pulse number whose cycle carries ABORT_i; -1 = abort in LOAD; 0 = none
   } vec_t;

   typedef struct {
      string       tag;
      logic        req;
      logic        abort;
      logic        ack;
      logic        err;
      logic        busy;
      logic        en;
      logic        done;
      logic        chk_ctr;
      logic [15:0] ctr;
   } cyc_t;

   cyc_t sbq[$];
   vec_t vt[11];
   int   n_vec;
   int   n_err;
   int   cyc;
   int   last_ctr;

   function automatic cyc_t mk(input string tag, input logic req, input logic abort,
                               input logic ack, input logic err, input logic busy,
                               input logic en, input logic done, input logic chk,
                               input int ctr);
      cyc_t r;
      r.tag = tag; r.req = req; r.abort = abort; r.ack = ack; r.err = err;
      r.busy = busy; r.en = en; r.done = done; r.chk_ctr = chk; r.ctr = 16'(ctr);
      return r;
   endfunction

   // Pulses in RUN cycles 0..k equal ceil(k*N/P), so cycle k pulses when that count steps.
   function automatic logic en_exp(input int k, input int n, input int p);
      if (k == 0) return 1'b0;
      return (((k * n + p - 1) / p) - (((k - 1) * n + p - 1) / p)) != 0;
   endfunction

   task automatic build_reject();
      sbq.push_back(mk("rej_req",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, last_ctr));
      sbq.push_back(mk("rej_err",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, last_ctr));
      sbq.push_back(mk("rej_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, last_ctr));
   endtask

   task automatic build_valid(input vec_t v, input logic hold, input bit first_idle);
      int   cnt;
      int   k;
      bit   fin;
      logic e;
      logic ab;
      cnt = 0;
      if (first_idle)
         sbq.push_back(mk("idle_req", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, last_ctr));
      sbq.push_back(mk("load", hold, logic'(v.abort_at < 0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0));
      if (v.abort_at < 0) begin
         sbq.push_back(mk("load_abort_idle", hold, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0));
      end else begin
         k   = 0;
         fin = 0;
         while (!fin && k < 500) begin
            e  = en_exp(k, v.n, v.p);
            ab = e && (v.abort_at > 0) && (cnt + 1 == v.abort_at);
            sbq.push_back(mk("run", hold, ab, 1'b0, 1'b0, 1'b1, e, 1'b0, 1'b1, cnt));
            if (e) cnt++;
            k++;
            if (ab) begin
               sbq.push_back(mk("abort_idle", hold, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cnt));
               fin = 1;
            end else if (e && v.t != 0 && cnt == v.t) begin
               sbq.push_back(mk("done", hold, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, cnt));
               sbq.push_back(mk("post_done_idle", hold, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cnt));
               fin = 1;
            end
         end
      end
      last_ctr = cnt;
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic run_queue();
      cyc_t       r;
      logic [4:0] got;
      logic [4:0] want;
      while (sbq.size() > 0) begin
         r         = sbq.pop_front();
         CFG_REQ_i = r.req;
         ABORT_i   = r.abort;
         @(negedge CK_i);
         got  = {CFG_ACK_o, CFG_ERR_o, BUSY_o, EN_CK_o, DONE_o};
         want = {r.ack, r.err, r.busy, r.en, r.done};
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d ack/err/busy/en/done got=%b want=%b", r.tag, cyc, got, want);
         end
         if (r.chk_ctr) begin
            n_vec++;
            if (TICK_CTR_o !== r.ctr) begin
               n_err++;
               $display("FAIL %s_ctr cyc=%0d tick_ctr got=%0d want=%0d", r.tag, cyc, TICK_CTR_o, r.ctr);
            end
         end
         cyc++;
         @(posedge CK_i);
         #1;
      end
      CFG_REQ_i = 1'b0;
      ABORT_i   = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      n_vec++;
      if ({CFG_ACK_o, CFG_ERR_o, BUSY_o, EN_CK_o, DONE_o} !== 5'b0 || TICK_CTR_o !== 16'd0) begin
         n_err++;
         $display("FAIL %s outputs got=%b ctr=%0d want=00000 ctr=0", tag,
                  {CFG_ACK_o, CFG_ERR_o, BUSY_o, EN_CK_o, DONE_o}, TICK_CTR_o);
      end
   endtask

   task automatic set_cfg(input vec_t v);
      CFG_PERIOD_i  = 16'(v.p);
      CFG_PULSE_N_i = 16'(v.n);
      CFG_TICKS_i   = 16'(v.t);
   endtask

   initial begin
      vec_t v;
      n_vec = 0; n_err = 0; cyc = 0; last_ctr = 0;
      vt[0]  = '{5, 6, 0, 0};
      vt[1]  = '{0, 0, 0, 0};
      vt[2]  = '{4, 0, 0, 0};
      vt[3]  = '{7, 3, 6, 0};
      vt[4]  = '{4, 4, 0, 10};
      vt[5]  = '{3, 1, 2, 2};
      vt[6]  = '{5, 2, 4, 0};
      vt[7]  = '{1, 1, 3, 0};
      vt[8]  = '{8, 5, 0, 7};
      vt[9]  = '{6, 1, 3, -1};
      vt[10] = '{9, 9, 2, 0};

      ARST_i = 1'b1; CFG_REQ_i = 1'b0; ABORT_i = 1'b0;
      CFG_PERIOD_i = '0; CFG_PULSE_N_i = '0; CFG_TICKS_i = '0;
      #12;
      check_zero("reset");
      #5;
      ARST_i = 1'b0;
      @(posedge CK_i);
      #1;

      for (int i = 0; i < 11; i++) begin
         set_cfg(vt[i]);
         if (vt[i].p == 0 || vt[i].n == 0 || vt[i].n > vt[i].p) build_reject();
         else build_valid(vt[i], 1'b0, 1'b1);
         run_queue();
      end

      // Request held through a whole burst is accepted again on the first IDLE cycle.
      v = '{3, 2, 2, 0};
      set_cfg(v);
      build_valid(v, 1'b1, 1'b1);
      build_valid(v, 1'b0, 1'b0);
      run_queue();

      // Asynchronous reset in the middle of a continuous burst.
      v = '{4, 4, 0, 0};
      set_cfg(v);
      sbq.push_back(mk("rst_idle_req", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, last_ctr));
      sbq.push_back(mk("rst_load", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0));
      sbq.push_back(mk("rst_run0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0));
      sbq.push_back(mk("rst_run1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0));
      sbq.push_back(mk("rst_run2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1));
      run_queue();
      n_vec++;
      if (EN_CK_o !== 1'b1 || BUSY_o !== 1'b1 || TICK_CTR_o !== 16'd2) begin
         n_err++;
         $display("FAIL pre_rst en=%b busy=%b ctr=%0d want en=1 busy=1 ctr=2", EN_CK_o, BUSY_o, TICK_CTR_o);
      end
      #2;
      ARST_i = 1'b1;
      #1;
      check_zero("mid_run_reset");
      #3;
      ARST_i = 1'b0;
      @(posedge CK_i);
      #1;
      last_ctr = 0;

      // First accept right after reset release.
      v = '{2, 1, 2, 0};
      set_cfg(v);
      build_valid(v, 1'b0, 1'b1);
      run_queue();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/subreg_tim_seq.md
SUBREG_TIM_SEQ -- requirements
Module: subreg_tim_seq

Interface
REQ-001 Parameter C_PERIOD_W, default 16: width of the period and pulse-count fields.
REQ-002 Parameter C_TICKS_W, default 16: width of the burst tick-count field and tick counter.
REQ-003 Port CK_i, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port ARST_i, input, 1: one clock; reset is asynchronous and active-high.
REQ-005 Port CFG_REQ_i, input, 1: configuration request; the requester holds it high until CFG_ACK_o or CFG_ERR_o.
REQ-006 Port CFG_PERIOD_i, input, C_PERIOD_W: period P in clocks.
REQ-007 Port CFG_PULSE_N_i, input, C_PERIOD_W: number of enable pulses N per period P.
REQ-008 Port CFG_TICKS_i, input, C_TICKS_W: burst length in enable pulses; 0 means continuous.
REQ-009 Port ABORT_i, input, 1: stop the active burst.
REQ-010 Port CFG_ACK_o, output, 1: one-cycle pulse, configuration accepted.
REQ-011 Port CFG_ERR_o, output, 1: one-cycle pulse, configuration rejected.
REQ-012 Port BUSY_o, output, 1: high whenever the state is not IDLE.
REQ-013 Port EN_CK_o, output, 1: evenly distributed clock-enable pulse.
REQ-014 Port DONE_o, output, 1: one-cycle pulse, burst completed normally.
REQ-015 Port TICK_CTR_o, output, C_TICKS_W: enable pulses emitted since the last accepted configuration.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, RUN and DONE.
REQ-017 In IDLE with CFG_REQ_i high: if P==0, N==0 or N>P, the block SHALL pulse CFG_ERR_o on the next cycle and stay in IDLE; otherwise it SHALL latch P/N/TICKS, clear TICK_CTR and the accumulator, and enter LOAD.
REQ-018 LOAD SHALL last exactly one cycle with CFG_ACK_o high, then go to RUN.
REQ-019 CFG_REQ_i SHALL be ignored in LOAD, RUN and DONE (no ACK, no ERR); a held request is evaluated on the first IDLE cycle.
REQ-020 Accumulator ACC SHALL be signed, C_PERIOD_W+1 bits, zero on entry to RUN; each RUN cycle ACC <= ACC - N + (ACC<0 ? P : 0).
REQ-021 EN_CK_o SHALL be (state==RUN) AND ACC sign bit, with no extra register stage; it SHALL be low in every other state.
REQ-022 For any valid P/N, every window of P consecutive RUN cycles SHALL contain exactly N EN_CK_o pulses; the first RUN cycle emits no pulse.
REQ-023 N==P SHALL give one low RUN cycle followed by continuous high.
REQ-024 TICK_CTR SHALL increment on each EN_CK_o pulse and wrap at 2^C_TICKS_W; it SHALL hold its value in IDLE.
REQ-025 When TICKS!=0 and a pulse brings TICK_CTR to TICKS, the FSM SHALL go to DONE on the next cycle; DONE SHALL pulse DONE_o for one cycle and then return to IDLE.
REQ-026 When TICKS==0, RUN SHALL continue until ABORT_i.
REQ-027 ABORT_i high in LOAD or RUN SHALL force IDLE on the next cycle with no DONE_o; a pulse emitted in that same cycle SHALL still be counted.
REQ-028 If ABORT_i coincides with the final tick, abort SHALL take priority: the FSM goes to IDLE and DONE_o stays low.
REQ-029 ABORT_i SHALL be ignored in IDLE and DONE.

Reset
REQ-030 ARST_i high SHALL immediately force state IDLE, ACC=0, TICK_CTR_o=0, and CFG_ACK_o, CFG_ERR_o, BUSY_o, EN_CK_o and DONE_o all 0, including mid-burst.
REQ-031 After ARST_i deasserts, the first accept SHALL be possible on the first rising edge where CFG_REQ_i is high.

Verification
REQ-032 P=7, N=3, TICKS=6: EN_CK_o over RUN cycles SHALL be L H L H L H L L H L H L H, then DONE_o on the cycle after the 6th pulse, BUSY_o low one cycle later, TICK_CTR_o=6.
REQ-033 Rejects: P=5,N=6; P=0,N=0; P=4,N=0 -> CFG_ERR_o pulse, no CFG_ACK_o, BUSY_o stays 0.
REQ-034 P=4, N=4, TICKS=0 -> first RUN cycle low, then EN_CK_o continuously high; ABORT_i after 10 pulses -> IDLE next cycle, TICK_CTR_o=10, no DONE_o.
REQ-035 P=3, N=1, TICKS=2, with ABORT_i on the cycle of the 2nd pulse -> TICK_CTR_o=2, DONE_o never asserts.
REQ-036 CFG_REQ_i held through a running burst -> no ACK until IDLE, accepted on the first IDLE cycle with TICK_CTR_o cleared; ARST_i pulse mid-RUN -> all outputs 0 immediately.
